// File: rtl/nios2_oci_dct_capture.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_dct_capture
// Description : Debug-capture-trace buffer for the Nios II OCI simulation
//               environment. Packed trace words with a non-zero field count
//               are stored in a DEPTH-entry FIFO and presented on a
//               valid/ready read port. End-of-test sequencing stops capture,
//               drains the FIFO (test_ending) or flushes it immediately
//               (test_has_ended), then raises a sticky drain_done.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               dct_buffer/count/valid - trace sample input
//               test_ending         - begin draining (level)
//               test_has_ended      - abort and flush (level)
//               rd_ready/rd_valid/rd_data - read port, {count, buffer}
//               fill_level          - entries held, 0..DEPTH
//               overflow/overflow_count - sticky drop flag, saturating count
//               drain_done          - sticky end-of-capture flag
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_oci_dct_capture #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [COUNT_W-1:0]        dct_count,
    input  logic                      dct_valid,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DATA_W+COUNT_W-1:0] rd_data,
    output logic [ADDR_W:0]           fill_level,
    output logic                      overflow,
    output logic [15:0]               overflow_count,
    output logic                      drain_done
);

    localparam int              c_entry_w    = DATA_W + COUNT_W;
    localparam logic [1:0]      c_st_capture = 2'd0;
    localparam logic [1:0]      c_st_drain   = 2'd1;
    localparam logic [1:0]      c_st_done    = 2'd2;
    localparam logic [ADDR_W:0] c_full_level = (ADDR_W + 1)'(DEPTH);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W:0]      r_fill;
    logic                 r_overflow;
    logic [15:0]          r_ovf_count;

    logic w_sample;
    logic w_full;
    logic w_rd;
    logic w_capture;
    logic w_wr;
    logic w_drop;
    logic w_abort;

    // A zero field count carries no trace data and is ignored outright.
    assign w_sample  = dct_valid && (dct_count != '0);
    assign w_full    = (r_fill == c_full_level);
    assign w_rd      = rd_valid && rd_ready;
    // An abort in the same cycle overrides capture; nothing is written.
    assign w_capture = (r_state == c_st_capture) && !test_has_ended;
    // When full, a simultaneous read frees the slot being written.
    assign w_wr      = w_capture && w_sample && (!w_full || w_rd);
    assign w_drop    = w_capture && w_sample && w_full && !w_rd;
    assign w_abort   = test_has_ended && (r_state != c_st_done);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_capture;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_capture: begin
                if (test_has_ended) begin
                    w_next_state = c_st_done;
                end else if (test_ending) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                // No writes while draining, so the post-read level is
                // simply the current level less this cycle's read.
                if (test_has_ended || (r_fill == (ADDR_W + 1)'(w_rd))) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_done;
            end
            default: begin
                w_next_state = c_st_capture;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_valid       = (r_fill != '0) && (r_state != c_st_done);
        rd_data        = rd_valid ? r_mem[r_rd_ptr] : '0;
        drain_done     = (r_state == c_st_done);
        fill_level     = r_fill;
        overflow       = r_overflow;
        overflow_count = r_ovf_count;
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    // ---------------- pointers, level, overflow accounting ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_fill   <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
                case ({w_wr, w_rd})
                    2'b10:   r_fill <= r_fill + (ADDR_W + 1)'(1);
                    2'b01:   r_fill <= r_fill - (ADDR_W + 1)'(1);
                    default: r_fill <= r_fill;
                endcase
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_ovf_count != 16'hFFFF) begin
                    r_ovf_count <= r_ovf_count + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_dct_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_oci_dct_capture
// Description : Directed self-checking bench for nios2_oci_dct_capture.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at the same point, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_oci_dct_capture;

    localparam int DATA_W  = 30;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;

    logic                      clk;
    logic                      reset;
    logic [DATA_W-1:0]         dct_buffer;
    logic [COUNT_W-1:0]        dct_count;
    logic                      dct_valid;
    logic                      test_ending;
    logic                      test_has_ended;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [DATA_W+COUNT_W-1:0] rd_data;
    logic [ADDR_W:0]           fill_level;
    logic                      overflow;
    logic [15:0]               overflow_count;
    logic                      drain_done;

    int n_chk = 0;
    int n_err = 0;

    nios2_oci_dct_capture #(
        .DATA_W (DATA_W),
        .COUNT_W(COUNT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .dct_valid     (dct_valid),
        .test_ending   (test_ending),
        .test_has_ended(test_has_ended),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .overflow_count(overflow_count),
        .drain_done    (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dct_buffer     = '0;
        dct_count      = '0;
        dct_valid      = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write1(input logic [3:0] c, input logic [29:0] d);
        dct_valid  = 1'b1;
        dct_count  = c;
        dct_buffer = d;
        tick();
        dct_valid  = 1'b0;
    endtask

    function automatic logic [3:0] cnt_of(input int k);
        return 4'((k % 15) + 1);
    endfunction

    logic [29:0] d;
    int          reads;

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        // ---------------- reset state ----------------
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_ovf_count", 64'(overflow_count), 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        reset = 1'b0;

        // ---------------- basic ----------------
        write1(4'd1, 30'h1);
        chk("basic_latency_valid", 64'(rd_valid), 64'd1);
        write1(4'd2, 30'h2);
        write1(4'd3, 30'h3);
        chk("basic_fill3", 64'(fill_level), 64'd3);
        chk("basic_head0", 64'(rd_data), 64'h4000_0001);
        rd_ready = 1'b1;
        tick();
        chk("basic_head1", 64'(rd_data), 64'h8000_0002);
        tick();
        chk("basic_head2", 64'(rd_data), 64'hC000_0003);
        tick();
        chk("basic_empty_valid", 64'(rd_valid), 64'd0);
        chk("basic_empty_fill", 64'(fill_level), 64'd0);
        rd_ready = 1'b0;

        // ---------------- full / overflow ----------------
        for (int i = 0; i < 20; i++) begin
            write1(4'hF, 30'(i));
        end
        chk("full_fill", 64'(fill_level), 64'd16);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_ovf_count", 64'(overflow_count), 64'd4);
        chk("full_head_stable", 64'(rd_data), {30'd0, 4'hF, 30'd0});
        dct_valid  = 1'b1;
        dct_count  = 4'hF;
        dct_buffer = 30'h3AA;
        rd_ready   = 1'b1;
        tick();
        dct_valid  = 1'b0;
        chk("full_wr_rd_fill", 64'(fill_level), 64'd16);
        chk("full_wr_rd_ovf", 64'(overflow_count), 64'd4);
        chk("full_wr_rd_head", 64'(rd_data), {30'd0, 4'hF, 30'd1});
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        chk("full_emptied", 64'(fill_level), 64'd0);
        chk("full_sticky", 64'(overflow), 64'd1);
        rd_ready = 1'b0;

        // ---------------- zero count ----------------
        do_reset();
        dct_valid = 1'b1;
        dct_count = 4'd0;
        dct_buffer = 30'h155;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        dct_valid = 1'b0;
        chk("zero_fill", 64'(fill_level), 64'd0);
        chk("zero_ovf_count", 64'(overflow_count), 64'd0);
        chk("zero_rd_valid", 64'(rd_valid), 64'd0);

        // ---------------- drain ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write1(4'd2, 30'h100 + 30'(i));
        end
        chk("drain_fill6", 64'(fill_level), 64'd6);
        test_ending = 1'b1;
        tick();
        chk("drain_not_done_yet", 64'(drain_done), 64'd0);
        dct_valid  = 1'b1;
        dct_count  = 4'd5;
        dct_buffer = 30'h2AB;
        rd_ready   = 1'b1;
        reads = 0;
        for (int i = 0; i < 20 && !drain_done; i++) begin
            if (rd_valid) begin
                d = 30'h100 + 30'(reads);
                chk("drain_data", 64'(rd_data), {30'd0, 4'd2, d});
                reads++;
            end
            tick();
        end
        chk("drain_reads", 64'(reads), 64'd6);
        chk("drain_done", 64'(drain_done), 64'd1);
        chk("drain_fill0", 64'(fill_level), 64'd0);
        chk("drain_ovf_count", 64'(overflow_count), 64'd0);
        tick();
        chk("drain_no_new", 64'(rd_valid), 64'd0);
        idle_inputs();

        // ---------------- abort ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            write1(4'd7, 30'h200 + 30'(i));
        end
        chk("abort_fill10", 64'(fill_level), 64'd10);
        test_has_ended = 1'b1;
        rd_ready       = 1'b1;
        tick();
        chk("abort_rd_valid", 64'(rd_valid), 64'd0);
        chk("abort_fill", 64'(fill_level), 64'd0);
        chk("abort_done", 64'(drain_done), 64'd1);
        test_has_ended = 1'b0;
        test_ending    = 1'b1;
        dct_valid      = 1'b1;
        dct_count      = 4'd1;
        dct_buffer     = 30'h77;
        tick();
        tick();
        tick();
        chk("abort_late_fill", 64'(fill_level), 64'd0);
        chk("abort_late_done", 64'(drain_done), 64'd1);
        chk("abort_late_valid", 64'(rd_valid), 64'd0);
        idle_inputs();

        // ---------------- wrap ----------------
        do_reset();
        write1(cnt_of(0), 30'd0);
        rd_ready  = 1'b1;
        dct_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            dct_count  = cnt_of(i);
            dct_buffer = 30'(i);
            d = 30'(i - 1);
            chk("wrap_data", 64'(rd_data), {30'd0, cnt_of(i - 1), d});
            tick();
        end
        idle_inputs();
        chk("wrap_fill", 64'(fill_level), 64'd1);
        chk("wrap_last", 64'(rd_data), {30'd0, cnt_of(40), 30'd40});

        // ---------------- reset mid-drain ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write1(4'd9, 30'h300 + 30'(i));
        end
        // Force a drop-free overflow-less state, then enter DRAIN.
        test_ending = 1'b1;
        tick();
        rd_ready = 1'b1;
        tick();
        chk("mid_drain_fill", 64'(fill_level), 64'd4);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_data", 64'(rd_data), 64'd0);
        chk("mid_rst_fill", 64'(fill_level), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_ovf_count", 64'(overflow_count), 64'd0);
        chk("mid_rst_done", 64'(drain_done), 64'd0);
        reset = 1'b0;
        idle_inputs();
        write1(4'd4, 30'h3C);
        chk("post_rst_capture_fill", 64'(fill_level), 64'd1);
        chk("post_rst_capture_data", 64'(rd_data), {30'd0, 4'd4, 30'h3C});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios2_oci_dct_capture.md
# nios2_oci_dct_capture

Parametrised debug-capture-trace (DCT) buffer for the Nios II OCI simulation environment. It takes packed trace words and their valid-field counts from the OCI, stores them in a DEPTH-entry FIFO, and exposes them over a valid/ready read port so benches can check them. On test end it stops capturing, drains, and signals completion. It adds widths, depth, buffering, overflow accounting and end-of-test sequencing to the earlier input-only OCI test-bench stub.

## Interface
- DATA_W, 30, width of dct_buffer trace word
- COUNT_W, 4, width of dct_count
- DEPTH, 16, FIFO entries; power of two, >= 2
- ADDR_W, 4, log2(DEPTH)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- dct_buffer  in  DATA_W  packed trace word
- dct_count  in  COUNT_W  number of valid fields in dct_buffer
- dct_valid  in  1  dct_buffer/dct_count qualify this cycle
- test_ending  in  1  level; test is winding down, begin drain
- test_has_ended  in  1  level; test finished, abort immediately
- rd_ready  in  1  consumer accepts rd_data this cycle
- rd_valid  out  1  FIFO non-empty and not aborted
- rd_data  out  DATA_W+COUNT_W  {count, buffer} at FIFO head
- fill_level  out  ADDR_W+1  entries held, 0..DEPTH
- overflow  out  1  sticky: at least one sample dropped for full
- overflow_count  out  16  dropped samples, saturates at 16'hFFFF
- drain_done  out  1  sticky: capture finished (drain or abort)

## Operation
- Reset values: rd_valid 0, rd_data 0, fill_level 0, overflow 0, overflow_count 0, drain_done 0; FSM in CAPTURE; pointers 0.
- Sample = dct_valid=1 and dct_count!=0. dct_valid with dct_count=0 is ignored, not stored, not counted.
- FSM states: CAPTURE, DRAIN, DONE.
- CAPTURE: samples are written. test_ending=1 -> DRAIN next cycle. test_has_ended=1 -> DONE. test_has_ended takes priority.
- DRAIN: samples are discarded silently, with no overflow count. Reads continue. fill_level==0 (after this cycle's read) -> DONE. test_has_ended=1 -> DONE.
- DONE: drain_done=1. If entered via test_has_ended, the FIFO is flushed: pointers and fill_level are 0 next cycle. Only reset leaves DONE.
- Write rule in CAPTURE: accept if not full, or if full and a read completes in the same cycle (level unchanged). Otherwise drop: overflow<=1, overflow_count+=1 (saturating).
- Read completes when rd_valid and rd_ready; head advances.
- Pointers are ADDR_W bits and wrap modulo DEPTH. fill_level is tracked separately: +1 on write only, -1 on read only, unchanged on both.
- rd_data = {stored dct_count, stored dct_buffer}, count in MSBs.

## Timing
- Write-to-read latency: a sample accepted at edge N gives rd_valid=1 and valid rd_data after edge N (cycle N+1). There is no same-cycle bypass.
- rd_data is stable while rd_valid=1 and rd_ready=0.
- fill_level, overflow and overflow_count are registered and update one edge after the causing event.
- CAPTURE->DRAIN: a sample in the same cycle test_ending first rises is still captured. Discarding starts the next cycle.
- Abort: test_has_ended at edge N -> rd_valid=0, drain_done=1 after edge N. A read handshake in that same cycle still completes.
- Reset asserted mid-operation clears everything at the next edge regardless of state or pending handshakes.

## Test plan
- Basic: write 3 samples (count 1,2,3; data 0x1,0x2,0x3) with rd_ready=0 -> fill_level=3. Then rd_ready=1 -> rd_data 0x4000_0001, 0x8000_0002, 0xC000_0003 in order, then rd_valid=0.
- Full/overflow: rd_ready=0, 20 samples -> fill_level=16, overflow=1, overflow_count=4. A write with simultaneous read while full -> fill_level stays 16, no count increment.
- Zero count: dct_valid=1, dct_count=0 for 5 cycles -> fill_level=0, overflow_count=0.
- Drain: 6 entries held, raise test_ending, keep writing, rd_ready=1 -> exactly 6 reads, then drain_done=1. No new entries, overflow_count unchanged.
- Abort: 10 entries, assert test_has_ended -> next cycle rd_valid=0, fill_level=0, drain_done=1. Later test_ending has no effect.
- Wrap and reset: 40 write/read pairs, then data order is intact. Reset mid-drain -> all outputs at reset values next cycle, FSM in CAPTURE.
